// File: rtl/mini68k_pkg.sv
// mini68k_pkg: shared decode definitions for the mini68k decode stage.
//   - opcode, effective-address (EA) mode and size encodings
//   - EXT_MAX: the most extension words one instruction can carry
//   - assembler FSM state encoding (S_OP / S_EXT / S_OUT)
//   - helpers: ea_ext_words, instr_ext_words, instr_illegal, decode_class
package mini68k_pkg;

   // Opcode field ir[15:12]
   localparam logic [3:0] OP_IMM     = 4'h0;
   localparam logic [3:0] OP_MOVE_B  = 4'h1;
   localparam logic [3:0] OP_MOVE_L  = 4'h2;
   localparam logic [3:0] OP_MOVE_W  = 4'h3;
   localparam logic [3:0] OP_MISC    = 4'h4;
   localparam logic [3:0] OP_BCC     = 4'h6;
   localparam logic [3:0] OP_ALU_OR  = 4'h8;
   localparam logic [3:0] OP_ALU_SUB = 4'h9;
   localparam logic [3:0] OP_LINE_A  = 4'hA;
   localparam logic [3:0] OP_ALU_AND = 4'hC;
   localparam logic [3:0] OP_ALU_ADD = 4'hD;
   localparam logic [3:0] OP_LINE_F  = 4'hF;

   // ir[11:6] selectors for JSR / JMP inside the OP_MISC line
   localparam logic [5:0] JSR_SEL = 6'b111010;
   localparam logic [5:0] JMP_SEL = 6'b111011;

   // EA modes that carry extension words
   localparam logic [2:0] EA_DISP  = 3'b101;
   localparam logic [2:0] EA_INDEX = 3'b110;
   localparam logic [2:0] EA_EXT   = 3'b111;

   // Register sub-field meanings when mode is EA_EXT
   localparam logic [2:0] EA_ABS_W    = 3'b000;
   localparam logic [2:0] EA_ABS_L    = 3'b001;
   localparam logic [2:0] EA_PC_DISP  = 3'b010;
   localparam logic [2:0] EA_PC_INDEX = 3'b011;
   localparam logic [2:0] EA_IMM      = 3'b100;

   // Operation sizes
   localparam logic [1:0] SIZE_B = 2'b00;
   localparam logic [1:0] SIZE_W = 2'b01;
   localparam logic [1:0] SIZE_L = 2'b10;

   localparam int EXT_MAX = 4;

   // Assembler FSM states
   typedef logic [1:0] state_t;
   localparam state_t S_OP  = 2'd0;
   localparam state_t S_EXT = 2'd1;
   localparam state_t S_OUT = 2'd2;

   // Class flags and size decoded from one opcode word
   typedef struct packed {
      logic       is_move;
      logic       is_alu;
      logic       is_branch;
      logic       is_jump;
      logic       is_immediate;
      logic       illegal;
      logic [1:0] size;
   } dec_t;

   function automatic logic is_move_op(input logic [3:0] op);
      return (op == OP_MOVE_B) || (op == OP_MOVE_W) || (op == OP_MOVE_L);
   endfunction

   // MOVE encodes its size in the opcode itself; every other class uses ir[7:6]
   function automatic logic [1:0] instr_size(input logic [15:0] ir);
      logic [1:0] size;
      size = ir[7:6];
      if (ir[15:12] == OP_MOVE_B)      size = SIZE_B;
      else if (ir[15:12] == OP_MOVE_W) size = SIZE_W;
      else if (ir[15:12] == OP_MOVE_L) size = SIZE_L;
      return size;
   endfunction

   function automatic logic [2:0] ea_ext_words(input logic [2:0] mode,
                                                input logic [2:0] ea_reg,
                                                input logic [1:0] size);
      logic [2:0] n;
      n = 3'd0;
      if (mode == EA_DISP || mode == EA_INDEX) begin
         n = 3'd1;
      end else if (mode == EA_EXT) begin
         case (ea_reg)
            EA_ABS_W, EA_PC_DISP, EA_PC_INDEX: n = 3'd1;
            EA_ABS_L: n = 3'd2;
            EA_IMM:   n = (size == SIZE_L) ? 3'd2 : 3'd1;
            default:  n = 3'd0;
         endcase
      end
      return n;
   endfunction

   // Total extension words following the opcode word; never exceeds EXT_MAX
   function automatic logic [2:0] instr_ext_words(input logic [15:0] ir);
      logic [1:0] size;
      logic [2:0] n;
      size = instr_size(ir);
      if (is_move_op(ir[15:12])) begin
         n = ea_ext_words(ir[5:3], ir[2:0], size) + ea_ext_words(ir[8:6], ir[11:9], size);
      end else if (ir[15:12] == OP_IMM) begin
         n = ((size == SIZE_L) ? 3'd2 : 3'd1) + ea_ext_words(ir[5:3], ir[2:0], size);
      end else if (ir[15:12] == OP_BCC) begin
         n = (ir[7:0] == 8'h00) ? 3'd1 : 3'd0;
      end else begin
         n = ea_ext_words(ir[5:3], ir[2:0], size);
      end
      return n;
   endfunction

   // Mode 111 with register 101..111 has no defined meaning
   function automatic logic ea_bad(input logic [2:0] mode, input logic [2:0] ea_reg);
      return (mode == EA_EXT) && (ea_reg > EA_IMM);
   endfunction

   function automatic logic instr_illegal(input logic [15:0] ir);
      logic bad;
      if (ir[15:12] == OP_LINE_A || ir[15:12] == OP_LINE_F) bad = 1'b1;
      else if (is_move_op(ir[15:12])) bad = ea_bad(ir[5:3], ir[2:0]) || ea_bad(ir[8:6], ir[11:9]);
      else if (ir[15:12] == OP_BCC)   bad = 1'b0;
      else                            bad = ea_bad(ir[5:3], ir[2:0]);
      return bad;
   endfunction

   // Class flags; illegal is left clear here and filled in by the stage
   function automatic dec_t decode_class(input logic [15:0] ir);
      dec_t d;
      d.is_move      = is_move_op(ir[15:12]);
      d.is_alu       = (ir[15:12] == OP_ALU_ADD) || (ir[15:12] == OP_ALU_SUB) ||
                       (ir[15:12] == OP_ALU_AND) || (ir[15:12] == OP_ALU_OR);
      d.is_branch    = (ir[15:12] == OP_BCC);
      d.is_jump      = (ir[15:12] == OP_MISC) && (ir[11:6] == JSR_SEL || ir[11:6] == JMP_SEL);
      d.is_immediate = (ir[15:12] == OP_IMM);
      d.illegal      = 1'b0;
      d.size         = instr_size(ir);
      return d;
   endfunction

endpackage

// File: rtl/mini68k_decode_if.sv
// mini68k_decode_if: fetch-side and execute-side handshake bundle of the
// decode stage.
//   slave  : the decode stage (takes fetch words, drives the decoded instruction)
//   master : the environment (fetch unit + execute control)
interface mini68k_decode_if #(parameter int ADDR_W = 24);
   logic              fetch_valid;
   logic              fetch_ready;
   logic [15:0]       fetch_word;
   logic              flush;
   logic [ADDR_W-1:0] flush_pc;
   logic              out_valid;
   logic              out_ready;
   logic [15:0]       out_ir;
   logic [63:0]       out_ext;
   logic [2:0]        out_ext_cnt;
   logic [ADDR_W-1:0] out_pc;
   logic [3:0]        out_opcode;
   logic [1:0]        out_op_size;
   logic              out_is_move;
   logic              out_is_alu;
   logic              out_is_branch;
   logic              out_is_jump;
   logic              out_is_immediate;
   logic              out_illegal;

   modport slave (
      input  fetch_valid, fetch_word, flush, flush_pc, out_ready,
      output fetch_ready, out_valid, out_ir, out_ext, out_ext_cnt, out_pc,
             out_opcode, out_op_size, out_is_move, out_is_alu, out_is_branch,
             out_is_jump, out_is_immediate, out_illegal
   );

   modport master (
      output fetch_valid, fetch_word, flush, flush_pc, out_ready,
      input  fetch_ready, out_valid, out_ir, out_ext, out_ext_cnt, out_pc,
             out_opcode, out_op_size, out_is_move, out_is_alu, out_is_branch,
             out_is_jump, out_is_immediate, out_illegal
   );
endinterface

// File: rtl/mini68k_fetch_fifo.sv
// mini68k_fetch_fifo: FIFO_DEPTH x 16 prefetch buffer (FIFO_DEPTH power of two).
//   clk, rst_n : clock, async active-low reset
//   clear      : drop every stored word (wins over push/pop)
//   push, din  : write din when not full
//   pop, dout  : dout is the head word; pop advances when not empty
//   count      : words currently stored (0..FIFO_DEPTH)
module mini68k_fetch_fifo #(
   parameter int FIFO_DEPTH = 4,
   localparam int PTR_W = $clog2(FIFO_DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             push,
   input  logic             pop,
   input  logic [15:0]      din,
   output logic [15:0]      dout,
   output logic [CNT_W-1:0] count
);

   logic [15:0]      mem_q [FIFO_DEPTH];
   logic [15:0]      mem_d [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             push_ok, pop_ok;

   // Pointers wrap naturally because the depth is a power of two
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      push_ok  = push && (count_q != CNT_W'(FIFO_DEPTH));
      pop_ok   = pop && (count_q != '0);
      if (clear) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_ok) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + 1'b1;
         end
         if (pop_ok) rd_ptr_d = rd_ptr_q + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q    <= '{default: '0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign dout  = mem_q[rd_ptr_q];
   assign count = count_q;

endmodule

// File: rtl/mini68k_decode_stage.sv
// mini68k_decode_stage: buffers fetched words, gathers each opcode word with
// its 0-4 extension words and presents one decoded instruction plus its PC.
//   clk, rst_n : clock, async active-low reset
//   bus        : mini68k_decode_if.slave
//                fetch_valid/fetch_ready/fetch_word : incoming words
//                flush/flush_pc                     : pipeline redirect
//                out_valid/out_ready + out_*        : decoded instruction
// Optional feature macro: MINI68K_DEC_ILLEGAL_EN flags illegal encodings
// (line A/F, mode 111 reg 101..111) and issues them with no extension words.
module mini68k_decode_stage
   import mini68k_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int ADDR_W     = 24,
   localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1
) (
   input logic clk,
   input logic rst_n,
   mini68k_decode_if.slave bus
);

   logic [CNT_W-1:0]       fifo_count;
   logic [15:0]            fifo_dout;
   logic                   fifo_push, fifo_pop, fifo_empty, load_op;

   state_t                 state_q, state_d;
   logic [ADDR_W-1:0]      pc_next_q, pc_next_d;
   logic [ADDR_W-1:0]      pc_q, pc_d;
   logic [15:0]            ir_q, ir_d;
   logic [EXT_MAX*16-1:0]  ext_q, ext_d;
   logic [2:0]             ext_cnt_q, ext_cnt_d;
   logic [1:0]             ext_idx_q, ext_idx_d;
   dec_t                   dec_q, dec_d, dec_new;
   logic [2:0]             cnt_new;

   // Words arriving during a flush are dropped; no push while full
   assign bus.fetch_ready = (fifo_count != CNT_W'(FIFO_DEPTH));
   assign fifo_push       = bus.fetch_valid && bus.fetch_ready && !bus.flush;
   assign fifo_empty      = (fifo_count == '0);

   mini68k_fetch_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (bus.flush),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .din   (bus.fetch_word),
      .dout  (fifo_dout),
      .count (fifo_count)
   );

   // Decode of the FIFO head, used whenever it is taken as an opcode word
   always_comb begin
      dec_new = decode_class(fifo_dout);
`ifdef MINI68K_DEC_ILLEGAL_EN
      dec_new.illegal = instr_illegal(fifo_dout);
      cnt_new = dec_new.illegal ? 3'd0 : instr_ext_words(fifo_dout);
`else
      cnt_new = instr_ext_words(fifo_dout);
`endif
   end

   // Assembler: S_OUT can hand off and take the next opcode in the same
   // cycle, which is what gives one zero-extension instruction per clock.
   always_comb begin
      state_d   = state_q;
      pc_next_d = pc_next_q;
      pc_d      = pc_q;
      ir_d      = ir_q;
      ext_d     = ext_q;
      ext_cnt_d = ext_cnt_q;
      ext_idx_d = ext_idx_q;
      dec_d     = dec_q;
      fifo_pop  = 1'b0;
      load_op   = 1'b0;
      if (bus.flush) begin
         state_d   = S_OP;
         pc_next_d = bus.flush_pc;
      end else begin
         case (state_q)
            S_OP: load_op = !fifo_empty;
            S_EXT: begin
               if (!fifo_empty) begin
                  fifo_pop = 1'b1;
                  for (int k = 0; k < EXT_MAX; k++) begin
                     if (ext_idx_q == 2'(k)) ext_d[k*16 +: 16] = fifo_dout;
                  end
                  ext_idx_d = ext_idx_q + 2'd1;
                  if ({1'b0, ext_idx_q} + 3'd1 == ext_cnt_q) state_d = S_OUT;
               end
            end
            S_OUT: begin
               if (bus.out_ready) begin
                  if (!fifo_empty) load_op = 1'b1;
                  else             state_d = S_OP;
               end
            end
            default: state_d = S_OP;
         endcase
         if (load_op) begin
            fifo_pop  = 1'b1;
            ir_d      = fifo_dout;
            pc_d      = pc_next_q;
            dec_d     = dec_new;
            ext_d     = '0;
            ext_cnt_d = cnt_new;
            ext_idx_d = 2'd0;
            state_d   = (cnt_new != 3'd0) ? S_EXT : S_OUT;
         end
         if (fifo_pop) pc_next_d = pc_next_q + ADDR_W'(2);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_OP;
         pc_next_q <= '0;
         pc_q      <= '0;
         ir_q      <= '0;
         ext_q     <= '0;
         ext_cnt_q <= '0;
         ext_idx_q <= '0;
         dec_q     <= '0;
      end else begin
         state_q   <= state_d;
         pc_next_q <= pc_next_d;
         pc_q      <= pc_d;
         ir_q      <= ir_d;
         ext_q     <= ext_d;
         ext_cnt_q <= ext_cnt_d;
         ext_idx_q <= ext_idx_d;
         dec_q     <= dec_d;
      end
   end

   assign bus.out_valid        = (state_q == S_OUT);
   assign bus.out_ir           = ir_q;
   assign bus.out_ext          = ext_q;
   assign bus.out_ext_cnt      = ext_cnt_q;
   assign bus.out_pc           = pc_q;
   assign bus.out_opcode       = ir_q[15:12];
   assign bus.out_op_size      = dec_q.size;
   assign bus.out_is_move      = dec_q.is_move;
   assign bus.out_is_alu       = dec_q.is_alu;
   assign bus.out_is_branch    = dec_q.is_branch;
   assign bus.out_is_jump      = dec_q.is_jump;
   assign bus.out_is_immediate = dec_q.is_immediate;
   assign bus.out_illegal      = dec_q.illegal;

endmodule
